// File: rtl/iram_arbiter.sv
// Two-port arbiter in front of the single synchronous-read IRAM port.
// Fetch (F) has priority; a saturating wait counter forces a debug (D)
// grant once D has been refused MAX_WAIT consecutive cycles.
//
// Handshake: a requester holds Req/Addr stable until it sees Gnt high in
// the same cycle; each cycle with Gnt high is exactly one accepted read,
// and Req still high afterwards is a new request. Rvalid is high exactly
// one cycle after the Gnt and cannot be stalled; Rdata is valid only in
// that cycle and reads as zero otherwise.
module iram_arbiter #(
  parameter int N        = 32,
  parameter int K        = 512,
  parameter int MAX_WAIT = 4,
  localparam int AW      = $clog2(K)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          F_Req,
  input  logic [AW-1:0] F_Addr,
  output logic          F_Gnt,
  output logic          F_Rvalid,
  output logic [N-1:0]  F_Rdata,
  input  logic          D_Req,
  input  logic [AW-1:0] D_Addr,
  output logic          D_Gnt,
  output logic          D_Rvalid,
  output logic [N-1:0]  D_Rdata,
  output logic [AW-1:0] Iram_Addr,
  input  logic [N-1:0]  Iram_Data,
  output logic [1:0]    dbg_owner,
  output logic [7:0]    dbg_wait_cnt
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_F = 2'd1,
    OWN_D = 2'd2
  } owner_t;

  owner_t     owner;
  logic [7:0] wait_cnt;

  // Priority arbitration: starved debug first, then fetch, then debug.
  always_comb begin
    F_Gnt = 1'b0;
    D_Gnt = 1'b0;
    if (D_Req && (wait_cnt == MAX_W)) begin
      D_Gnt = 1'b1;
    end else if (F_Req) begin
      F_Gnt = 1'b1;
    end else if (D_Req) begin
      D_Gnt = 1'b1;
    end
  end

  // IRAM address follows fetch unless debug owns this cycle's read.
  always_comb begin
    Iram_Addr = D_Gnt ? D_Addr : F_Addr;
  end

  // Count consecutive refused debug cycles, saturating at MAX_WAIT.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wait_cnt <= 8'd0;
    end else if (!D_Req || D_Gnt) begin
      wait_cnt <= 8'd0;
    end else if (wait_cnt < MAX_W) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Owner FSM: remembers who issued the read now returning from the IRAM.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      owner    <= IDLE;
      F_Rvalid <= 1'b0;
      D_Rvalid <= 1'b0;
    end else begin
      if (F_Gnt) begin
        owner <= OWN_F;
      end else if (D_Gnt) begin
        owner <= OWN_D;
      end else begin
        owner <= IDLE;
      end
      F_Rvalid <= F_Gnt;
      D_Rvalid <= D_Gnt;
    end
  end

  // Zero-gate the shared read data toward each requester.
  always_comb begin
    F_Rdata = F_Rvalid ? Iram_Data : '0;
    D_Rdata = D_Rvalid ? Iram_Data : '0;
  end

  // Debug visibility of internal state.
  always_comb begin
    dbg_owner    = owner;
    dbg_wait_cnt = wait_cnt;
  end

endmodule

// File: tb/tb_iram_arbiter.sv
// Testbench for iram_arbiter: directed vector table, reset-mid-read
// sequence, and a random phase checked against a scoreboard.
module tb_iram_arbiter;

  localparam int N        = 32;
  localparam int K        = 512;
  localparam int AW       = 9;
  localparam int MAX_WAIT = 4;

  logic          Clk;
  logic          Rst;
  logic          F_Req;
  logic [AW-1:0] F_Addr;
  logic          F_Gnt;
  logic          F_Rvalid;
  logic [N-1:0]  F_Rdata;
  logic          D_Req;
  logic [AW-1:0] D_Addr;
  logic          D_Gnt;
  logic          D_Rvalid;
  logic [N-1:0]  D_Rdata;
  logic [AW-1:0] Iram_Addr;
  logic [N-1:0]  Iram_Data;
  logic [1:0]    dbg_owner;
  logic [7:0]    dbg_wait_cnt;

  int pass_cnt;
  int total_cnt;

  iram_arbiter #(.N(N), .K(K), .MAX_WAIT(MAX_WAIT)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .F_Req        (F_Req),
    .F_Addr       (F_Addr),
    .F_Gnt        (F_Gnt),
    .F_Rvalid     (F_Rvalid),
    .F_Rdata      (F_Rdata),
    .D_Req        (D_Req),
    .D_Addr       (D_Addr),
    .D_Gnt        (D_Gnt),
    .D_Rvalid     (D_Rvalid),
    .D_Rdata      (D_Rdata),
    .Iram_Addr    (Iram_Addr),
    .Iram_Data    (Iram_Data),
    .dbg_owner    (dbg_owner),
    .dbg_wait_cnt (dbg_wait_cnt)
  );

  // ---------------- clock / reset / IRAM model ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  logic [N-1:0] mem [0:K-1];
  initial begin
    for (int i = 0; i < K; i++) mem[i] = N'(i + 32'h100);
  end

  always @(posedge Clk) Iram_Data <= mem[Iram_Addr];

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          f_gnt;
    logic          d_gnt;
    logic          f_rv;
    logic          d_rv;
    logic [N-1:0]  f_rd;
    logic [N-1:0]  d_rd;
    logic [7:0]    wc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fr, input logic [AW-1:0] fa, input logic dr, input logic [AW-1:0] da,
                     input logic fg, input logic dg, input logic frv, input logic drv,
                     input logic [N-1:0] frd, input logic [N-1:0] drd, input logic [7:0] wc);
    vec_t v;
    v.f_req = fr; v.f_addr = fa; v.d_req = dr; v.d_addr = da;
    v.f_gnt = fg; v.d_gnt = dg; v.f_rv = frv; v.d_rv = drv;
    v.f_rd = frd; v.d_rd = drd; v.wc = wc;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard for the random phase ----------------
  logic [N-1:0] exp_f_q[$];
  logic [N-1:0] exp_d_q[$];

  initial begin
    logic         f_rv_exp, d_rv_exp, exp_fg, exp_dg;
    logic [N-1:0] exp_data;
    int           d_refused;

    pass_cnt  = 0;
    total_cnt = 0;
    Rst    = 1'b0;
    F_Req  = 1'b0;
    F_Addr = '0;
    D_Req  = 1'b0;
    D_Addr = '0;

    // Columns: f_req f_addr d_req d_addr | f_gnt d_gnt f_rv d_rv f_rdata d_rdata wait_cnt
    // Fetch stream
    add(1, 9'h000, 0, 9'h000, 1, 0, 0, 0, 32'h000, 32'h000, 8'd0);
    add(1, 9'h001, 0, 9'h000, 1, 0, 1, 0, 32'h100, 32'h000, 8'd0);
    add(1, 9'h002, 0, 9'h000, 1, 0, 1, 0, 32'h101, 32'h000, 8'd0);
    add(1, 9'h003, 0, 9'h000, 1, 0, 1, 0, 32'h102, 32'h000, 8'd0);
    add(0, 9'h000, 0, 9'h000, 0, 0, 1, 0, 32'h103, 32'h000, 8'd0);
    // Debug alone, top address
    add(0, 9'h000, 1, 9'h1FF, 0, 1, 0, 0, 32'h000, 32'h000, 8'd0);
    add(0, 9'h000, 0, 9'h000, 0, 0, 0, 1, 32'h000, 32'h2FF, 8'd0);
    // Starvation guard: 12 cycles of dual requests, D wins cycles 5 and 10
    add(1, 9'h010, 1, 9'h080, 1, 0, 0, 0, 32'h000, 32'h000, 8'd0);
    add(1, 9'h011, 1, 9'h080, 1, 0, 1, 0, 32'h110, 32'h000, 8'd1);
    add(1, 9'h012, 1, 9'h080, 1, 0, 1, 0, 32'h111, 32'h000, 8'd2);
    add(1, 9'h013, 1, 9'h080, 1, 0, 1, 0, 32'h112, 32'h000, 8'd3);
    add(1, 9'h014, 1, 9'h080, 0, 1, 1, 0, 32'h113, 32'h000, 8'd4);
    add(1, 9'h014, 1, 9'h081, 1, 0, 0, 1, 32'h000, 32'h180, 8'd0);
    add(1, 9'h015, 1, 9'h081, 1, 0, 1, 0, 32'h114, 32'h000, 8'd1);
    add(1, 9'h016, 1, 9'h081, 1, 0, 1, 0, 32'h115, 32'h000, 8'd2);
    add(1, 9'h017, 1, 9'h081, 1, 0, 1, 0, 32'h116, 32'h000, 8'd3);
    add(1, 9'h018, 1, 9'h081, 0, 1, 1, 0, 32'h117, 32'h000, 8'd4);
    add(1, 9'h018, 1, 9'h082, 1, 0, 0, 1, 32'h000, 32'h181, 8'd0);
    add(1, 9'h019, 1, 9'h082, 1, 0, 1, 0, 32'h118, 32'h000, 8'd1);
    add(0, 9'h000, 0, 9'h000, 0, 0, 1, 0, 32'h119, 32'h000, 8'd2);
    // Contention release: F drops after two cycles, D granted in cycle 3
    add(1, 9'h020, 1, 9'h040, 1, 0, 0, 0, 32'h000, 32'h000, 8'd0);
    add(1, 9'h021, 1, 9'h040, 1, 0, 1, 0, 32'h120, 32'h000, 8'd1);
    add(0, 9'h022, 1, 9'h040, 0, 1, 1, 0, 32'h121, 32'h000, 8'd2);
    add(0, 9'h000, 0, 9'h000, 0, 0, 0, 1, 32'h000, 32'h140, 8'd0);
    add(0, 9'h000, 0, 9'h000, 0, 0, 0, 0, 32'h000, 32'h000, 8'd0);

    // Reset state
    #1;
    check("reset_f_rvalid", 64'(F_Rvalid), 64'd0);
    check("reset_d_rvalid", 64'(D_Rvalid), 64'd0);
    check("reset_f_rdata", 64'(F_Rdata), 64'd0);
    check("reset_d_rdata", 64'(D_Rdata), 64'd0);
    check("reset_wait_cnt", 64'(dbg_wait_cnt), 64'd0);
    check("reset_owner", 64'(dbg_owner), 64'd0);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge Clk);
      #1;
      F_Req  = vecs[i].f_req;
      F_Addr = vecs[i].f_addr;
      D_Req  = vecs[i].d_req;
      D_Addr = vecs[i].d_addr;
      @(negedge Clk);
      check($sformatf("v%0d_f_gnt", i), 64'(F_Gnt), 64'(vecs[i].f_gnt));
      check($sformatf("v%0d_d_gnt", i), 64'(D_Gnt), 64'(vecs[i].d_gnt));
      check($sformatf("v%0d_iram_addr", i), 64'(Iram_Addr),
            64'(vecs[i].d_gnt ? vecs[i].d_addr : vecs[i].f_addr));
      check($sformatf("v%0d_f_rvalid", i), 64'(F_Rvalid), 64'(vecs[i].f_rv));
      check($sformatf("v%0d_d_rvalid", i), 64'(D_Rvalid), 64'(vecs[i].d_rv));
      check($sformatf("v%0d_f_rdata", i), 64'(F_Rdata), 64'(vecs[i].f_rd));
      check($sformatf("v%0d_d_rdata", i), 64'(D_Rdata), 64'(vecs[i].d_rd));
      check($sformatf("v%0d_wait_cnt", i), 64'(dbg_wait_cnt), 64'(vecs[i].wc));
    end

    // Reset mid-read: grant, then reset while the response is showing
    @(posedge Clk);
    #1;
    F_Req  = 1'b1;
    F_Addr = 9'h005;
    @(negedge Clk);
    check("rst_seq_f_gnt", 64'(F_Gnt), 64'd1);
    @(posedge Clk);
    #1 F_Req = 1'b0;
    #1;
    check("rst_seq_pre_rvalid", 64'(F_Rvalid), 64'd1);
    check("rst_seq_pre_rdata", 64'(F_Rdata), 64'h105);
    #1 Rst = 1'b0;
    #1;
    check("rst_seq_f_rvalid", 64'(F_Rvalid), 64'd0);
    check("rst_seq_f_rdata", 64'(F_Rdata), 64'd0);
    check("rst_seq_owner", 64'(dbg_owner), 64'd0);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check($sformatf("rst_seq_idle%0d_f_rvalid", i), 64'(F_Rvalid), 64'd0);
      check($sformatf("rst_seq_idle%0d_d_rvalid", i), 64'(D_Rvalid), 64'd0);
    end

    // Random phase with held-until-granted requests
    f_rv_exp  = 1'b0;
    d_rv_exp  = 1'b0;
    exp_fg    = 1'b0;
    exp_dg    = 1'b0;
    d_refused = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(posedge Clk);
      #1;
      if (!F_Req || exp_fg) begin
        F_Req  = 1'($urandom_range(0, 1));
        F_Addr = AW'($urandom_range(0, K - 1));
      end
      if (!D_Req || exp_dg) begin
        D_Req  = ($urandom_range(0, 3) != 0);
        D_Addr = AW'($urandom_range(0, K - 1));
      end
      @(negedge Clk);
      exp_dg = D_Req && ((d_refused == MAX_WAIT) || !F_Req);
      exp_fg = F_Req && !exp_dg;
      check("rnd_f_gnt", 64'(F_Gnt), 64'(exp_fg));
      check("rnd_d_gnt", 64'(D_Gnt), 64'(exp_dg));
      check("rnd_iram_addr", 64'(Iram_Addr), 64'(exp_dg ? D_Addr : F_Addr));
      check("rnd_wait_cnt", 64'(dbg_wait_cnt), 64'(d_refused));
      check("rnd_f_rvalid", 64'(F_Rvalid), 64'(f_rv_exp));
      check("rnd_d_rvalid", 64'(D_Rvalid), 64'(d_rv_exp));
      exp_data = '0;
      if (f_rv_exp && exp_f_q.size() > 0) exp_data = exp_f_q.pop_front();
      check("rnd_f_rdata", 64'(F_Rdata), 64'(exp_data));
      exp_data = '0;
      if (d_rv_exp && exp_d_q.size() > 0) exp_data = exp_d_q.pop_front();
      check("rnd_d_rdata", 64'(D_Rdata), 64'(exp_data));
      if (exp_fg) exp_f_q.push_back(mem[F_Addr]);
      if (exp_dg) exp_d_q.push_back(mem[D_Addr]);
      f_rv_exp = exp_fg;
      d_rv_exp = exp_dg;
      d_refused = (D_Req && !exp_dg) ? d_refused + 1 : 0;
      check("rnd_d_refused_bound", 64'(d_refused <= MAX_WAIT), 64'd1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
